// File: rtl/serial_word_loader_pkg.sv
// Shared definitions for serial_word_loader: FSM state encodings and word-count width.
package serial_word_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_PARITY = 2'd3
  } state_t;

  localparam int WCNT_W = 8;

endpackage

// File: rtl/serial_word_loader_bit_counter.sv
// Bit counter for serial_word_loader: clear has priority over enable; terminal flags
// that the bit currently being accepted is the last data bit of the word.
module bit_counter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_word_loader.sv
// MSB-first serial-to-parallel word loader feeding a register's load/d inputs.
// Optional even-parity check after each word is enabled with `define PARITY_CHECK_EN.
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              sin,
  input  logic              sin_valid,
  output logic              busy,
  output logic              load,
  output logic [WIDTH-1:0]  d,
  output logic              frame_err,
  output logic [WCNT_W-1:0] word_count
);

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_next;
  logic [WIDTH-1:0] d_next;
  logic             terminal;
  logic             cnt_clear, cnt_en, shift_en;
  logic             load_next, d_en, wc_inc, busy_next;
`ifdef PARITY_CHECK_EN
  logic             ferr_next;
`endif

  assign word_next = {shreg[WIDTH-2:0], sin};

  bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .terminal (terminal)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    shift_en   = 1'b0;
    load_next  = 1'b0;
    d_en       = 1'b0;
    d_next     = word_next;
    wc_inc     = 1'b0;
`ifdef PARITY_CHECK_EN
    ferr_next  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SHIFT;
          cnt_clear  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (sin_valid) begin
          shift_en = 1'b1;
          cnt_en   = 1'b1;
          if (terminal) begin
`ifdef PARITY_CHECK_EN
            state_next = ST_PARITY;
`else
            state_next = ST_LOAD;
            load_next  = 1'b1;
            d_en       = 1'b1;
`endif
          end
        end
      end
      ST_LOAD: begin
        wc_inc = 1'b1;
        if (start) begin
          state_next = ST_SHIFT;
          cnt_clear  = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_PARITY: begin
`ifdef PARITY_CHECK_EN
        // The full word is already in shreg; sin carries only the parity bit here.
        if (abort) begin
          state_next = ST_IDLE;
        end else if (sin_valid) begin
          if ((^shreg ^ sin) == 1'b0) begin
            state_next = ST_LOAD;
            load_next  = 1'b1;
            d_en       = 1'b1;
            d_next     = shreg;
          end else begin
            state_next = ST_IDLE;
            ferr_next  = 1'b1;
          end
        end
`else
        state_next = ST_IDLE;
`endif
      end
    endcase
    busy_next = (state_next == ST_SHIFT) || (state_next == ST_PARITY);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg      <= '0;
      d          <= '0;
      load       <= 1'b0;
      busy       <= 1'b0;
      word_count <= '0;
    end else begin
      load <= load_next;
      busy <= busy_next;
      if (shift_en) begin
        shreg <= word_next;
      end
      if (d_en) begin
        d <= d_next;
      end
      if (wc_inc) begin
        word_count <= word_count + WCNT_W'(1);
      end
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= ferr_next;
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed scoreboard bench for serial_word_loader (16-bit words).
module tb_serial_word_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        sin = 1'b0;
  logic        sin_valid = 1'b0;
  logic        busy;
  logic        load;
  logic [15:0] d;
  logic        frame_err;
  logic [7:0]  word_count;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  exp_wc = '0;
  logic        prev_load = 1'b0;

  serial_word_loader #(
    .WIDTH (16),
    .CNT_W (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .busy       (busy),
    .load       (load),
    .d          (d),
    .frame_err  (frame_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every load strobe must deliver the oldest expected word.
  always @(negedge clk) begin
    if (!reset) begin
      exp_wc    = '0;
      prev_load = 1'b0;
    end else begin
      if (load) begin
        chk("load_while_busy", {31'd0, busy}, 32'd0);
        chk("load_width", {31'd0, prev_load}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_load", 32'd1, 32'd0);
        end else begin
          chk("d_word", {16'd0, d}, {16'd0, exp_q.pop_front()});
        end
        chk("word_count_pre", {24'd0, word_count}, {24'd0, exp_wc});
        exp_wc = exp_wc + 8'd1;
      end
      prev_load = load;
    end
  end

  task automatic start_word();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Shifts 16 bits MSB first; gap_len idle cycles after accepted bit indices ga/gb.
  // With parity enabled, a parity bit follows (inverted when bad_par).
  task automatic shift_word(input logic [15:0] w, input int ga, input int gb,
                            input int gap_len, input bit bad_par);
    for (int k = 0; k < 16; k++) begin
      sin       = w[15-k];
      sin_valid = 1'b1;
      tick();
      sin_valid = 1'b0;
      if (k < 15) chk("busy_shift", {31'd0, busy}, 32'd1);
      if (k == ga || k == gb) begin
        for (int g = 0; g < gap_len; g++) begin
          tick();
          chk("no_load_in_gap", {31'd0, load}, 32'd0);
        end
      end
    end
`ifdef PARITY_CHECK_EN
    chk("busy_parity", {31'd0, busy}, 32'd1);
    chk("no_early_load", {31'd0, load}, 32'd0);
    sin       = (^w) ^ bad_par;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
    if (bad_par) begin
      chk("frame_err_pulse", {31'd0, frame_err}, 32'd1);
      chk("no_load_bad_par", {31'd0, load}, 32'd0);
    end else begin
      chk("load_latency", {31'd0, load}, 32'd1);
      chk("frame_err_clear", {31'd0, frame_err}, 32'd0);
    end
`else
    chk("load_latency", {31'd0, load}, 32'd1);
    chk("frame_err_zero", {31'd0, frame_err}, 32'd0);
`endif
    chk("not_busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    logic [7:0]  wc_before;

    // Reset with start and sin_valid active.
    reset = 1'b0; start = 1'b1; sin_valid = 1'b1; sin = 1'b1;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_load", {31'd0, load}, 32'd0);
    chk("rst_d", {16'd0, d}, 32'h0000);
    chk("rst_wc", {24'd0, word_count}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    reset = 1'b1; start = 1'b0; sin_valid = 1'b0; sin = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Basic word.
    exp_q.push_back(16'h00aa);
    start_word();
    shift_word(16'h00aa, -1, -1, 0, 1'b0);
    tick();
    chk("load_one_cycle", {31'd0, load}, 32'd0);
    chk("wc_after_basic", {24'd0, word_count}, 32'd1);
    tick();
    chk("d_holds", {16'd0, d}, 32'h00aa);

    // Start coincident with sin_valid: that bit must be ignored.
    exp_q.push_back(16'h4242);
    start = 1'b1; sin = 1'b1; sin_valid = 1'b1;
    tick();
    start = 1'b0; sin_valid = 1'b0;
    chk("busy_after_start2", {31'd0, busy}, 32'd1);
    shift_word(16'h4242, 4, 11, 3, 1'b0);
    tick();
    chk("load_one_cycle_gap", {31'd0, load}, 32'd0);
    chk("wc_after_gaps", {24'd0, word_count}, 32'd2);
    chk("d_after_gaps", {16'd0, d}, 32'h4242);

    // Abort after 9 bits of ffff, with sin_valid also high.
    start_word();
    for (int k = 0; k < 9; k++) begin
      sin = 1'b1; sin_valid = 1'b1;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0; sin_valid = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_load", {31'd0, load}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      sin = 1'b1; sin_valid = 1'b1;
      tick();
    end
    sin_valid = 1'b0;
    tick();
    chk("abort_no_load", {31'd0, load}, 32'd0);
    chk("abort_d", {16'd0, d}, 32'h4242);
    chk("abort_wc", {24'd0, word_count}, 32'd2);

`ifdef PARITY_CHECK_EN
    // Good parity.
    exp_q.push_back(16'h00aa);
    start_word();
    shift_word(16'h00aa, -1, -1, 0, 1'b0);
    tick();
    chk("par_good_d", {16'd0, d}, 32'h00aa);
    chk("par_good_wc", {24'd0, word_count}, 32'd3);
    // Bad parity: same word, parity bit 1.
    exp_q.push_back(16'h1234);
    start_word();
    shift_word(16'h1234, -1, -1, 0, 1'b0);
    tick();
    start_word();
    shift_word(16'h00aa, -1, -1, 0, 1'b1);
    tick();
    chk("par_bad_ferr_pulse", {31'd0, frame_err}, 32'd0);
    chk("par_bad_d", {16'd0, d}, 32'h1234);
    chk("par_bad_wc", {24'd0, word_count}, 32'd4);
`endif

    // Back-to-back from reset: 256 words, start asserted during LOAD.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst2_wc", {24'd0, word_count}, 32'd0);
    for (int n = 0; n < 256; n++) begin
      w = 16'(($urandom() & 32'hffff) ^ 32'(n));
      exp_q.push_back(w);
      if (n == 0) start_word();
      shift_word(w, -1, -1, 0, 1'b0);
      wc_before = word_count;
      if (n < 255) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_no_gap", {31'd0, busy}, 32'd1);
        chk("b2b_wc", {24'd0, word_count}, {24'd0, 8'(wc_before + 8'd1)});
      end else begin
        tick();
      end
    end
    chk("wrap_wc", {24'd0, word_count}, 32'd0);
    chk("final_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("final_load", {31'd0, load}, 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
